// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Define PS2_HOST_TX_RETRY_EN to retry a failed frame once before reporting tx_err.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              n_q, n_d;
    logic [10:0]             sh_q, sh_d;
    logic [SYNC_STAGES-1:0]  kclk_sync_q, kdata_sync_q;
    logic                    kclk_prev_q;
    logic                    kclk_s, kdata_s, fall, timeout, take_err;
`ifdef PS2_HOST_TX_RETRY_EN
    logic                    retry_q, retry_d;
    logic [7:0]              data_q, data_d;
`endif

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Lines idle high, so the synchronisers reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_sync_q  <= '1;
            kdata_sync_q <= '1;
            kclk_prev_q  <= 1'b1;
        end else begin
            kclk_sync_q  <= {kclk_sync_q[SYNC_STAGES-2:0], kclk_in};
            kdata_sync_q <= {kdata_sync_q[SYNC_STAGES-2:0], kdata_in};
            kclk_prev_q  <= kclk_s;
        end
    end

    assign kclk_s  = kclk_sync_q[SYNC_STAGES-1];
    assign kdata_s = kdata_sync_q[SYNC_STAGES-1];
    assign fall    = kclk_prev_q & ~kclk_s;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign busy    = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            sh_q    <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q <= 1'b0;
            data_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q <= retry_d;
            data_q  <= data_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        sh_d     = sh_q;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d  = retry_q;
        data_d   = data_q;
`endif
        take_err = 1'b0;
        tx_ready = 1'b0;
        kclk_oe  = 1'b0;
        kdata_oe = 1'b0;
        tx_done  = 1'b0;
        tx_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    sh_d    = frame_of(tx_data);
`ifdef PS2_HOST_TX_RETRY_EN
                    data_d  = tx_data;
`endif
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                kclk_oe = 1'b1;
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REQ: begin
                kclk_oe  = 1'b1;
                kdata_oe = 1'b1;
                n_d      = '0;
                cnt_d    = '0;
                state_d  = S_SEND;
            end
            S_SEND: begin
                kdata_oe = ~sh_q[0];
                if (timeout) begin
                    take_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (fall) begin
                        sh_d = {1'b1, sh_q[10:1]};
                        n_d  = n_q + 4'd1;
                        if (n_q == 4'd9) state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (timeout) begin
                    take_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (fall) begin
                        if (!kdata_s) state_d = S_WAIT_IDLE;
                        else          take_err = 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (timeout) begin
                    take_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (kclk_s && kdata_s) state_d = S_DONE;
                end
            end
            S_DONE: begin
                tx_done = 1'b1;
                cnt_d   = '0;
`ifdef PS2_HOST_TX_RETRY_EN
                retry_d = 1'b0;
`endif
                state_d = S_IDLE;
            end
            S_ERR: begin
                tx_err  = 1'b1;
                cnt_d   = '0;
`ifdef PS2_HOST_TX_RETRY_EN
                retry_d = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (take_err) begin
`ifdef PS2_HOST_TX_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                sh_d    = frame_of(data_q);
                n_d     = '0;
                cnt_d   = '0;
                state_d = S_INHIBIT;
            end else begin
                state_d = S_ERR;
            end
`else
            state_d = S_ERR;
`endif
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, etc.) to the keyboard over the same kclk/kdata pair the receive path listens on.
- Drives both lines open-drain through active-high "pull low" enables. The top level builds the tristates from these enables.
- Sits beside the keyboard receiver under the input controller. The receiver ignores the bus while `busy` is high.

Parameters:
- INHIBIT_CYCLES, 10000: clk cycles the clock line is held low before request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles from clock release to end of ACK before aborting (20 ms at 100 MHz).
- SYNC_STAGES, 2: flip-flop synchroniser depth on kclk_in and kdata_in; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send; sampled on accept
- tx_valid  in  1  request to send
- tx_ready  out  1  high only in IDLE; accept happens when tx_valid && tx_ready
- kclk_in  in  1  raw PS/2 clock line level
- kdata_in  in  1  raw PS/2 data line level
- kclk_oe  out  1  1 = pull clock line low
- kdata_oe  out  1  1 = pull data line low
- busy  out  1  high from accept until the DONE/ERR cycle, inclusive
- tx_done  out  1  one-cycle pulse: byte sent and ACK received
- tx_err  out  1  one-cycle pulse: missing ACK or timeout

Behaviour:
- Reset values: tx_ready=1, kclk_oe=0, kdata_oe=0, busy=0, tx_done=0, tx_err=0. State is IDLE and all counters are 0.
- Reset is honoured in any state; mid-frame reset releases both lines immediately (asynchronously).
- Input conditioning:
  - kclk_in and kdata_in each pass through a SYNC_STAGES flip-flop chain, giving kclk_s and kdata_s.
  - A falling edge (fall) is kclk_s moving 1→0 between consecutive cycles.
- Frame contents: shift register sh[10:0] = {1'b1 stop, parity, tx_data[7:0], 1'b0 start}.
  - parity = ~^tx_data (odd parity). Example: 0xED gives parity 1; 0x00 gives parity 1; 0x01 gives parity 0.
- States:
  - IDLE: tx_ready=1.
    - On accept, latch sh and go to INHIBIT.
    - kclk_oe rises on the cycle after accept.
  - INHIBIT: kclk_oe=1, kdata_oe=0.
    - Count INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: one cycle with kclk_oe=1 and kdata_oe=1 (start bit presented).
    - Next state SEND, with bit counter n=0.
    - Clear the timeout counter.
  - SEND: kclk_oe=0, kdata_oe=~sh[0].
    - On each fall: shift sh right by one and increment n.
    - After the fall with n==10 (stop bit now driven, kdata_oe=0), go to ACK.
    - Data is only changed on falls, i.e. while the device clock is low.
  - ACK: both oe=0.
    - On the next fall, sample kdata_s.
    - Sample 0: go to WAIT_IDLE.
    - Sample 1: go to ERR.
  - WAIT_IDLE: wait for kclk_s=1 and kdata_s=1 on the same cycle, then go to DONE.
  - DONE: tx_done=1 for one cycle, then IDLE.
  - ERR: tx_err=1 for one cycle, both oe=0, then IDLE.
- Timeout:
  - The counter runs in SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES-1: go to ERR and release both lines.
  - If a fall lands on the same cycle, the timeout takes priority.
- tx_valid while busy is ignored; tx_data is not re-sampled.
- The device pulling kclk low during INHIBIT is not detected; the host owns the line.
- Latency: accept → first kclk_oe=1 is 1 cycle; accept → kdata_oe=1 is INHIBIT_CYCLES+1 cycles.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - The first error (ACK sampled 1, or timeout) does not pulse tx_err. Instead the block re-enters INHIBIT with the latched byte, and busy stays high.
  - A second consecutive error pulses tx_err.
  - The retry flag clears on DONE, on ERR and on reset.
- Undefined: every error goes directly to ERR; no retry logic is synthesised.

Test Plan:
- Reset mid-SEND (after 4 falls): both oe drop to 0 asynchronously, tx_ready=1, busy=0; a new 0xFF then sends cleanly with tx_done.
- Send 0xED, device model clocks at 12.5 kHz and samples on rising edges, ACKs low:
  - device decodes start 0, data bits LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - one tx_done pulse; kclk_oe high for exactly INHIBIT_CYCLES+1 cycles (INHIBIT plus REQ).
- Send 0x01, device does not ACK (data stays high on the 11th fall): tx_err pulses once, no tx_done. With PS2_HOST_TX_RETRY_EN, a second full frame is seen before tx_err.
- Device never clocks after REQ: tx_err exactly TIMEOUT_CYCLES cycles after leaving REQ; kdata_oe=0 afterwards.
- tx_valid held high through a whole transfer with tx_data changing to 0xAA mid-frame: device receives only the originally latched byte; second accept only after returning to IDLE.
- Glitch on kclk_in of 1 clk cycle during SEND: counted as one fall (no filtering), documented as an expected frame failure. The bench checks tx_err fires via missing ACK or timeout.
